// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues single-beat AXI4 reads to the icache and hands each word to the IDU.
// Optional performance counters are built when IFU_PERF_EN is defined.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter logic [3:0]  ARID     = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_arready,
    output logic        out_arvalid,
    output logic [31:0] out_araddr,
    output logic [3:0]  out_arid,
    output logic [7:0]  out_arlen,
    output logic [2:0]  out_arsize,
    output logic [1:0]  out_arburst,
    output logic        out_rready,
    input  logic        out_rvalid,
    input  logic [1:0]  out_rresp,
    input  logic [31:0] out_rdata,
    input  logic        out_rlast,
    input  logic [3:0]  out_rid,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_fault,
    input  logic        npc_valid,
    input  logic [31:0] npc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        SEND = 3'd3,
        WAIT = 3'd4
    } state_t;

    state_t state_r;
    state_t state_s;

    logic unused_s;
    assign unused_s = ^{out_rlast, out_rid, npc[1:0]};

    assign out_araddr  = pc;
    assign out_arid    = ARID;
    assign out_arlen   = 8'd0;
    assign out_arsize  = 3'b010;
    assign out_arburst = 2'b01;

    // Next-state logic for the fetch loop.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: state_s = AR;
            AR: begin
                if (out_arready) state_s = R;
                else             state_s = AR;
            end
            R: begin
                if (out_rvalid) state_s = SEND;
                else            state_s = R;
            end
            SEND: begin
                if (inst_ready) state_s = WAIT;
                else            state_s = SEND;
            end
            WAIT: begin
                if (npc_valid) state_s = AR;
                else           state_s = WAIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, registered handshake flags (decoded from next state) and fetched data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            out_arvalid <= 1'b0;
            out_rready  <= 1'b0;
            inst_valid  <= 1'b0;
            pc          <= RESET_PC;
            inst        <= 32'd0;
            inst_fault  <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_arvalid <= (state_s == AR);
            out_rready  <= (state_s == R);
            inst_valid  <= (state_s == SEND);
            if (state_r == R && out_rvalid) begin
                inst       <= out_rdata;
                inst_fault <= (out_rresp != 2'b00);
            end
            // pc moves only on a WBU redirect, word aligned.
            if (state_r == WAIT && npc_valid) begin
                pc <= {npc[31:2], 2'b00};
            end
        end
    end

`ifdef IFU_PERF_EN
    // Fetch and stall counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (state_r == R && out_rvalid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((state_r == AR && !out_arready) || (state_r == R && !out_rvalid)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; outputs are sampled 1 ns after each rising edge.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_arready;
    logic        out_arvalid;
    logic [31:0] out_araddr;
    logic [3:0]  out_arid;
    logic [7:0]  out_arlen;
    logic [2:0]  out_arsize;
    logic [1:0]  out_arburst;
    logic        out_rready;
    logic        out_rvalid;
    logic [1:0]  out_rresp;
    logic [31:0] out_rdata;
    logic        out_rlast;
    logic [3:0]  out_rid;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;
    logic        npc_valid;
    logic [31:0] npc;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int vectors_applied = 0;
    int miscompares     = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .out_arready(out_arready),
        .out_arvalid(out_arvalid),
        .out_araddr (out_araddr),
        .out_arid   (out_arid),
        .out_arlen  (out_arlen),
        .out_arsize (out_arsize),
        .out_arburst(out_arburst),
        .out_rready (out_rready),
        .out_rvalid (out_rvalid),
        .out_rresp  (out_rresp),
        .out_rdata  (out_rdata),
        .out_rlast  (out_rlast),
        .out_rid    (out_rid),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc         (pc),
        .inst_fault (inst_fault),
        .npc_valid  (npc_valid),
        .npc        (npc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; out_arready = 1'b0; out_rvalid = 1'b0; out_rresp = 2'b00;
        out_rdata = 32'd0; out_rlast = 1'b1; out_rid = 4'd0;
        inst_ready = 1'b0; npc_valid = 1'b0; npc = 32'd0;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("rst_arvalid", {31'd0, out_arvalid}, 32'd0);
            check_vec("rst_rready", {31'd0, out_rready}, 32'd0);
            check_vec("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        check_vec("rst_pc", pc, 32'h3000_0000);
        rst = 1'b1;
        tick();
        check_vec("first_arvalid", {31'd0, out_arvalid}, 32'd1);
        check_vec("first_araddr", out_araddr, 32'h3000_0000);
        check_vec("arlen", {24'd0, out_arlen}, 32'd0);
        check_vec("arsize", {29'd0, out_arsize}, 32'd2);
        check_vec("arburst", {30'd0, out_arburst}, 32'd1);
        check_vec("arid", {28'd0, out_arid}, 32'd0);

        // AR stall for 5 cycles; npc_valid asserted from here on must be ignored
        npc_valid = 1'b1; npc = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec("ar_hold_valid", {31'd0, out_arvalid}, 32'd1);
            check_vec("ar_hold_addr", out_araddr, 32'h3000_0000);
        end
        out_arready = 1'b1;
        tick();
        out_arready = 1'b0;
        check_vec("r_rready", {31'd0, out_rready}, 32'd1);
        check_vec("r_arvalid", {31'd0, out_arvalid}, 32'd0);
        tick();
        check_vec("r_wait_rready", {31'd0, out_rready}, 32'd1);
        check_vec("r_pc_ignored", pc, 32'h3000_0000);

        // Good beat, IDU stalls 3 cycles
        out_rvalid = 1'b1; out_rdata = 32'h0000_0413; out_rresp = 2'b00;
        tick();
        out_rvalid = 1'b0; out_rdata = 32'hFFFF_FFFF;
        check_vec("send_rready", {31'd0, out_rready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_vec("send_valid", {31'd0, inst_valid}, 32'd1);
            check_vec("send_inst", inst, 32'h0000_0413);
            check_vec("send_pc", pc, 32'h3000_0000);
            check_vec("send_fault", {31'd0, inst_fault}, 32'd0);
            tick();
        end
        npc_valid = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check_vec("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_vec("wait_arvalid", {31'd0, out_arvalid}, 32'd0);
        npc_valid = 1'b1; npc = 32'h8000_0006;
        tick();
        npc_valid = 1'b0;
        check_vec("redirect_arvalid", {31'd0, out_arvalid}, 32'd1);
        check_vec("redirect_araddr", out_araddr, 32'h8000_0004);

        // SLVERR beat
        out_arready = 1'b1;
        tick();
        out_arready = 1'b0;
        out_rvalid = 1'b1; out_rresp = 2'b10; out_rdata = 32'hDEAD_BEEF;
        tick();
        out_rvalid = 1'b0;
        check_vec("err_valid", {31'd0, inst_valid}, 32'd1);
        check_vec("err_fault", {31'd0, inst_fault}, 32'd1);
        check_vec("err_inst", inst, 32'hDEAD_BEEF);
        check_vec("err_pc", pc, 32'h8000_0004);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        npc_valid = 1'b1; npc = 32'h3000_0004;
        tick();
        npc_valid = 1'b0;
        check_vec("after_err_araddr", out_araddr, 32'h3000_0004);
        check_vec("after_err_arvalid", {31'd0, out_arvalid}, 32'd1);
        out_arready = 1'b1;
        tick();
        out_arready = 1'b0;
        out_rvalid = 1'b1; out_rresp = 2'b00; out_rdata = 32'h0000_0013;
        tick();
        out_rvalid = 1'b0;
        check_vec("clr_fault", {31'd0, inst_fault}, 32'd0);
        check_vec("clr_inst", inst, 32'h0000_0013);
        check_vec("clr_pc", pc, 32'h3000_0004);
`ifdef IFU_PERF_EN
        check_vec("perf_fetch", perf_fetch_cnt, 32'd3);
        check_vec("perf_stall", perf_stall_cnt, 32'd6);
`endif

        // Reset while in R with a beat pending
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        npc_valid = 1'b1; npc = 32'h1234_5678;
        tick();
        npc_valid = 1'b0;
        check_vec("pre_rst_araddr", out_araddr, 32'h1234_5678);
        out_arready = 1'b1;
        tick();
        out_arready = 1'b0;
        check_vec("pre_rst_rready", {31'd0, out_rready}, 32'd1);
        out_rvalid = 1'b1; out_rdata = 32'hAAAA_5555;
        rst = 1'b0;
        tick();
        check_vec("mid_rst_rready", {31'd0, out_rready}, 32'd0);
        check_vec("mid_rst_arvalid", {31'd0, out_arvalid}, 32'd0);
        check_vec("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_vec("mid_rst_inst", inst, 32'd0);
        check_vec("mid_rst_pc", pc, 32'h3000_0000);
`ifdef IFU_PERF_EN
        check_vec("perf_fetch_rst", perf_fetch_cnt, 32'd0);
        check_vec("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
        rst = 1'b1; out_rvalid = 1'b0;
        tick();
        check_vec("restart_arvalid", {31'd0, out_arvalid}, 32'd1);
        check_vec("restart_araddr", out_araddr, 32'h3000_0000);
        check_vec("restart_rready", {31'd0, out_rready}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
